// File: rtl/timer_bank_pkg.sv
// Shared definitions for the timer bank: register map, mode encoding and CTRL layout.
package timer_bank_pkg;

  localparam logic [1:0] REG_LOAD    = 2'd0;
  localparam logic [1:0] REG_CTRL    = 2'd1;
  localparam logic [1:0] REG_CNT_CMP = 2'd2;
  localparam logic [1:0] REG_STAT    = 2'd3;

  typedef enum logic [1:0] {
    MODE_ONESHOT = 2'd0,
    MODE_AUTO    = 2'd1,
    MODE_PWM     = 2'd2,
    MODE_STOP    = 2'd3
  } mode_e;

  localparam int unsigned CTRL_EN_BIT     = 0;
  localparam int unsigned CTRL_MODE_LSB   = 1;
  localparam int unsigned CTRL_IRQ_EN_BIT = 3;
  localparam int unsigned CTRL_PRESC_LSB  = 8;
  localparam int unsigned PRESC_W         = 8;

  typedef struct packed {
    logic [PRESC_W-1:0] presc;
    logic               irq_en;
    mode_e              mode;
    logic               en;
  } ctrl_t;

  // Bus view of a CTRL register; unused bits read as zero.
  function automatic logic [31:0] pack_ctrl(input ctrl_t c);
    return {16'h0000, c.presc, 4'h0, c.irq_en, c.mode, c.en};
  endfunction

endpackage

// File: rtl/timer_channel.sv
// One timer channel: prescaler, down-counter, mode handling and pending bit.
// TIMER_BANK_PWM_EN enables the PWM mode and its compare register.
module timer_channel
  import timer_bank_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we_load,
  input  logic             we_ctrl,
  input  logic             we_cmp,
  input  logic             we_stat,
  input  logic [31:0]      wdata,
  output logic [WIDTH-1:0] load,
  output logic [WIDTH-1:0] count,
  output ctrl_t            ctrl,
  output logic             pending,
  output logic             ch_out,
  output logic             irq_req_c
);

  logic [WIDTH-1:0]   load_q, load_d;
  logic [WIDTH-1:0]   count_q, count_d;
  logic [PRESC_W-1:0] pc_q, pc_d;
  ctrl_t              ctrl_q, ctrl_d;
  logic               pending_q, pending_d;
  logic               out_q, out_d;
  mode_e              mode_eff;
  logic               running, start, tick, expire;

`ifdef TIMER_BANK_PWM_EN
  logic [WIDTH-1:0]   cmp_q, cmp_d;
`else
  logic               unused_cmp;
  assign unused_cmp = we_cmp;
`endif

  // Decode effective mode and this cycle's start/tick/expiry events.
  always_comb begin
`ifdef TIMER_BANK_PWM_EN
    mode_eff = ctrl_q.mode;
`else
    mode_eff = (ctrl_q.mode == MODE_PWM) ? MODE_STOP : ctrl_q.mode;
`endif
    running = ctrl_q.en && (mode_eff != MODE_STOP);
    start   = we_ctrl && wdata[CTRL_EN_BIT] && !ctrl_q.en;
    tick    = running && !start && (pc_q == ctrl_q.presc);
    expire  = tick && (count_q == '0);
  end

  // Next state: register writes, then counting; start overrides a tick.
  always_comb begin
    load_d    = load_q;
    count_d   = count_q;
    pc_d      = pc_q;
    ctrl_d    = ctrl_q;
    pending_d = pending_q;
    out_d     = out_q;
`ifdef TIMER_BANK_PWM_EN
    cmp_d     = cmp_q;
    if (we_cmp) cmp_d = wdata[WIDTH-1:0];
`endif
    if (we_load) load_d = wdata[WIDTH-1:0];
    if (we_ctrl) begin
      ctrl_d.en     = wdata[CTRL_EN_BIT];
      ctrl_d.mode   = mode_e'(wdata[CTRL_MODE_LSB +: 2]);
      ctrl_d.irq_en = wdata[CTRL_IRQ_EN_BIT];
      ctrl_d.presc  = wdata[CTRL_PRESC_LSB +: PRESC_W];
    end
    if (we_stat && wdata[0]) pending_d = 1'b0;

    if (start) begin
      count_d = load_q;
      pc_d    = '0;
      out_d   = 1'b0;
    end else if (running) begin
      pc_d = tick ? '0 : pc_q + PRESC_W'(1);
      if (expire) begin
        pending_d = 1'b1;
        case (mode_eff)
          MODE_ONESHOT: begin
            ctrl_d.en = 1'b0;
            out_d     = 1'b1;
          end
          MODE_AUTO: begin
            count_d = load_q;
            out_d   = ~out_q;
          end
          default: count_d = load_q;
        endcase
      end else if (tick) begin
        count_d = count_q - WIDTH'(1);
      end
    end else if (mode_eff == MODE_ONESHOT) begin
      out_d = 1'b0;
    end

`ifdef TIMER_BANK_PWM_EN
    if (running && !start && (mode_eff == MODE_PWM)) out_d = (count_d < cmp_q);
`endif
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      load_q    <= '0;
      count_q   <= '0;
      pc_q      <= '0;
      ctrl_q    <= '0;
      pending_q <= 1'b0;
      out_q     <= 1'b0;
`ifdef TIMER_BANK_PWM_EN
      cmp_q     <= '0;
`endif
    end else begin
      load_q    <= load_d;
      count_q   <= count_d;
      pc_q      <= pc_d;
      ctrl_q    <= ctrl_d;
      pending_q <= pending_d;
      out_q     <= out_d;
`ifdef TIMER_BANK_PWM_EN
      cmp_q     <= cmp_d;
`endif
    end
  end

  assign load      = load_q;
  assign count     = count_q;
  assign ctrl      = ctrl_q;
  assign pending   = pending_q;
  assign ch_out    = out_q;
  assign irq_req_c = pending_q & ctrl_q.irq_en;

endmodule

// File: rtl/timer_bank.sv
// Multi-channel programmable timer on the MIO bus: decode, read mux and irq.
// TIMER_BANK_PWM_EN enables PWM mode and the per-channel CMP register.
module timer_bank
  import timer_bank_pkg::*;
#(
  parameter int unsigned NCH   = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    we,
  input  logic [$clog2(NCH)+1:0]  addr,
  input  logic [31:0]             wdata,
  output logic [31:0]             rdata,
  output logic [NCH-1:0]          ch_out,
  output logic                    irq
);

  localparam int unsigned AW = $clog2(NCH) + 2;

  logic [AW-1:0]    ch_sel;
  logic [1:0]       reg_sel;
  logic [WIDTH-1:0] load_w  [NCH];
  logic [WIDTH-1:0] count_w [NCH];
  ctrl_t            ctrl_w  [NCH];
  logic [NCH-1:0]   pending_w;
  logic [NCH-1:0]   irq_req_w;
  logic [31:0]      rdata_q, rdata_d;
  logic             irq_q, irq_d;

  assign ch_sel  = addr >> 2;
  assign reg_sel = addr[1:0];

  for (genvar i = 0; i < int'(NCH); i++) begin : g_ch
    logic hit;
    assign hit = we && (ch_sel == AW'(i));

    timer_channel #(.WIDTH(WIDTH)) u_ch (
      .clk       (clk),
      .rst       (rst),
      .we_load   (hit && (reg_sel == REG_LOAD)),
      .we_ctrl   (hit && (reg_sel == REG_CTRL)),
      .we_cmp    (hit && (reg_sel == REG_CNT_CMP)),
      .we_stat   (hit && (reg_sel == REG_STAT)),
      .wdata     (wdata),
      .load      (load_w[i]),
      .count     (count_w[i]),
      .ctrl      (ctrl_w[i]),
      .pending   (pending_w[i]),
      .ch_out    (ch_out[i]),
      .irq_req_c (irq_req_w[i])
    );
  end

  // Read mux over the pre-write register state; out-of-range channels read 0.
  always_comb begin
    rdata_d = '0;
    irq_d   = |irq_req_w;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (ch_sel == AW'(i)) begin
        case (reg_sel)
          REG_LOAD:    rdata_d = 32'(load_w[i]);
          REG_CTRL:    rdata_d = pack_ctrl(ctrl_w[i]);
          REG_CNT_CMP: rdata_d = 32'(count_w[i]);
          default:     rdata_d = 32'(pending_w[i]);
        endcase
      end
    end
  end

  // Registered read data and interrupt.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
      irq_q   <= 1'b0;
    end else begin
      rdata_q <= rdata_d;
      irq_q   <= irq_d;
    end
  end

  assign rdata = rdata_q;
  assign irq   = irq_q;

endmodule

// File: tb/tb_timer_bank.sv
// Bench for timer_bank (NCH=8, WIDTH=16): directed scenarios plus random bus
// traffic, all checked against a cycle-level behavioural model of the channels.
module tb_timer_bank;

  localparam int unsigned NCH   = 8;
  localparam int unsigned WIDTH = 16;
  localparam int unsigned AW    = 5;
  localparam int unsigned MASK  = 32'h0000_FFFF;
`ifdef TIMER_BANK_PWM_EN
  localparam bit PWM_ON = 1'b1;
`else
  localparam bit PWM_ON = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst, we;
  logic [AW-1:0]  addr;
  logic [31:0]    wdata, rdata;
  logic [NCH-1:0] ch_out;
  logic           irq;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  int unsigned m_load[NCH], m_count[NCH], m_cmp[NCH], m_presc[NCH], m_pc[NCH], m_mode[NCH];
  bit          m_en[NCH], m_irqen[NCH], m_pend[NCH], m_out[NCH];
  logic [31:0] m_rdata;
  bit          m_irq;

  timer_bank #(.NCH(NCH), .WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst    (rst),
    .we     (we),
    .addr   (addr),
    .wdata  (wdata),
    .rdata  (rdata),
    .ch_out (ch_out),
    .irq    (irq)
  );

  always #5 clk = ~clk;

  function automatic int unsigned eff_mode(input int unsigned md);
    return (!PWM_ON && md == 2) ? 3 : md;
  endfunction

  function automatic logic [31:0] m_read(input int unsigned c, input int unsigned rg);
    case (rg)
      0:       return 32'(m_load[c]);
      1:       return 32'((m_presc[c] << 8) | (32'(m_irqen[c]) << 3) | (m_mode[c] << 1) | 32'(m_en[c]));
      2:       return 32'(m_count[c]);
      default: return 32'(m_pend[c]);
    endcase
  endfunction

  function automatic logic [NCH-1:0] m_outv();
    logic [NCH-1:0] v;
    for (int i = 0; i < int'(NCH); i++) v[i] = m_out[i];
    return v;
  endfunction

  // Advance the model by one clock edge with the given bus inputs.
  task automatic model_step(input bit r, input bit w, input int unsigned a, input logic [31:0] d);
    int unsigned c, rg;
    if (r) begin
      for (int i = 0; i < int'(NCH); i++) begin
        m_load[i] = 0; m_count[i] = 0; m_cmp[i] = 0; m_presc[i] = 0; m_pc[i] = 0;
        m_mode[i] = 0; m_en[i] = 0; m_irqen[i] = 0; m_pend[i] = 0; m_out[i] = 0;
      end
      m_rdata = '0;
      m_irq   = 0;
      return;
    end
    c  = a >> 2;
    rg = a & 3;
    m_rdata = m_read(c, rg);
    m_irq = 0;
    for (int i = 0; i < int'(NCH); i++) if (m_pend[i] && m_irqen[i]) m_irq = 1;
    for (int i = 0; i < int'(NCH); i++) begin
      bit sel, run, start, tick, expire;
      int unsigned md, old_load, old_cmp;
      sel      = w && (c == i);
      md       = eff_mode(m_mode[i]);
      run      = m_en[i] && (md != 3);
      start    = sel && rg == 1 && d[0] && !m_en[i];
      tick     = run && !start && (m_pc[i] == m_presc[i]);
      expire   = tick && (m_count[i] == 0);
      old_load = m_load[i];
      old_cmp  = m_cmp[i];
      if (sel && rg == 0) m_load[i] = d & MASK;
      if (sel && rg == 2 && PWM_ON) m_cmp[i] = d & MASK;
      if (sel && rg == 1) begin
        m_en[i]    = d[0];
        m_mode[i]  = (d >> 1) & 3;
        m_irqen[i] = d[3];
        m_presc[i] = (d >> 8) & 8'hFF;
      end
      if (sel && rg == 3 && d[0]) m_pend[i] = 0;
      if (start) begin
        m_count[i] = old_load;
        m_pc[i]    = 0;
        m_out[i]   = 0;
      end else if (run) begin
        m_pc[i] = tick ? 0 : (m_pc[i] + 1) % 256;
        if (expire) begin
          m_pend[i] = 1;
          if (md == 0) begin
            m_en[i]  = 0;
            m_out[i] = 1;
          end else begin
            m_count[i] = old_load;
            if (md == 1) m_out[i] = !m_out[i];
          end
        end else if (tick) begin
          m_count[i] = m_count[i] - 1;
        end
        if (md == 2) m_out[i] = (m_count[i] < old_cmp);
      end else if (md == 0) begin
        m_out[i] = 0;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // One bus cycle; outputs are compared to the model on the falling edge.
  task automatic cycle(input bit r, input bit w, input logic [AW-1:0] a, input logic [31:0] d);
    rst   = r;
    we    = w;
    addr  = a;
    wdata = d;
    @(posedge clk);
    model_step(r, w, int'(a), d);
    @(negedge clk);
    chk("rdata_model", rdata, m_rdata);
    chk("ch_out_model", 32'(ch_out), 32'(m_outv()));
    chk("irq_model", 32'(irq), 32'(m_irq));
    we = 1'b0;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [31:0] d);
    cycle(1'b0, 1'b1, a, d);
  endtask

  task automatic idle(input logic [AW-1:0] a);
    cycle(1'b0, 1'b0, a, 32'h0);
  endtask

  initial begin
    int high, tog0, tog7;
    logic p0, p7;
    logic [AW-1:0] ra;
    logic [31:0]   rd;
    bit            rw, rr;
    rst = 1'b1; we = 1'b0; addr = '0; wdata = '0;

    // Reset with random traffic, then every register reads zero
    for (int k = 0; k < 2; k++) cycle(1'b1, 1'($urandom), AW'($urandom), $urandom);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_ch_out", 32'(ch_out), 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    for (int a = 0; a < 32; a++) begin
      idle(AW'(a));
      chk("rst_reg", rdata, 32'h0);
    end

    // One-shot on ch0
    wr(5'd0, 32'd3);
    wr(5'd1, 32'h9);
    for (int j = 1; j <= 5; j++) begin
      idle(5'd1);
      chk("os_out", 32'(ch_out[0]), 32'(j == 4));
      if (j >= 4) chk("os_irq", 32'(irq), 32'(j == 5));
    end
    idle(5'd1);
    chk("os_ctrl", rdata, 32'h8);
    wr(5'd3, 32'h1);
    chk("os_irq_hold", 32'(irq), 32'h1);
    idle(5'd3);
    chk("os_irq_clr", 32'(irq), 32'h0);

    // Auto-reload with prescaler on ch1
    wr(5'd4, 32'd4);
    wr(5'd5, 32'h103);
    for (int j = 1; j <= 22; j++) begin
      idle(5'd6);
      chk("ar_count", rdata, 32'(4 - ((j - 1) % 10) / 2));
      chk("ar_out", 32'(ch_out[1]), 32'((j >= 10) ^ (j >= 20)));
    end

    // PWM on ch2 (or frozen when PWM is compiled out)
    wr(5'd8, 32'd9);
    wr(5'd10, 32'd3);
    wr(5'd9, 32'h5);
`ifdef TIMER_BANK_PWM_EN
    high = 0;
    for (int j = 1; j <= 20; j++) begin idle(5'd10); high += int'(ch_out[2]); end
    chk("pwm_duty3", 32'(high), 32'd6);
    wr(5'd10, 32'd0);
    high = 0;
    for (int j = 1; j <= 20; j++) begin idle(5'd10); high += int'(ch_out[2]); end
    chk("pwm_cmp0", 32'(high), 32'd0);
    wr(5'd10, 32'd12);
    high = 0;
    for (int j = 1; j <= 20; j++) begin idle(5'd10); high += int'(ch_out[2]); end
    chk("pwm_cmp12", 32'(high), 32'd20);
    wr(5'd9, 32'h4);
`else
    for (int j = 1; j <= 6; j++) begin
      idle(5'd10);
      chk("stop_count", rdata, 32'd9);
      chk("stop_out", 32'(ch_out[2]), 32'h0);
    end
`endif

    // Clear racing an expiry: pending survives
    wr(5'd12, 32'd0);
    wr(5'd13, 32'h3);
    idle(5'd15);
    wr(5'd15, 32'h1);
    idle(5'd15);
    chk("col_stat_set", rdata, 32'h1);
    wr(5'd13, 32'h0);
    wr(5'd15, 32'h1);
    idle(5'd15);
    chk("col_stat_clr", rdata, 32'h0);

    // Re-enable reloads COUNT from LOAD with no tick
    wr(5'd16, 32'd5);
    wr(5'd17, 32'h3);
    for (int j = 0; j < 3; j++) idle(5'd18);
    wr(5'd17, 32'h2);
    idle(5'd18);
    wr(5'd17, 32'h3);
    idle(5'd18);
    chk("col_en_load", rdata, 32'd5);

    // LOAD rewrite mid-count affects only the next period
    wr(5'd20, 32'd3);
    wr(5'd21, 32'h3);
    wr(5'd20, 32'd6);
    for (int j = 2; j <= 12; j++) begin
      idle(5'd22);
      if (j == 3)  chk("ld_out3", 32'(ch_out[5]), 32'h0);
      if (j == 4)  chk("ld_out4", 32'(ch_out[5]), 32'h1);
      if (j == 10) chk("ld_out10", 32'(ch_out[5]), 32'h1);
      if (j == 11) chk("ld_out11", 32'(ch_out[5]), 32'h0);
    end

    // Width truncation and two concurrent channels
    wr(5'd28, 32'hFFFF_1234);
    idle(5'd28);
    chk("ld_trunc", rdata, 32'h0000_1234);
    wr(5'd0, 32'd2);
    wr(5'd28, 32'd4);
    wr(5'd1, 32'hB);
    wr(5'd29, 32'hB);
    p0 = ch_out[0]; p7 = ch_out[7]; tog0 = 0; tog7 = 0;
    for (int j = 0; j < 30; j++) begin
      idle(5'd31);
      if (ch_out[0] != p0) tog0++;
      if (ch_out[7] != p7) tog7++;
      p0 = ch_out[0]; p7 = ch_out[7];
    end
    chk("conc_tog0", 32'(tog0), 32'd10);
    chk("conc_tog7", 32'(tog7), 32'd6);
    chk("conc_irq", 32'(irq), 32'h1);

    // Reset mid-count
    cycle(1'b1, 1'b1, 5'd1, 32'h3);
    chk("mid_rst_rdata", rdata, 32'h0);
    chk("mid_rst_out", 32'(ch_out), 32'h0);
    chk("mid_rst_irq", 32'(irq), 32'h0);
    idle(5'd30);
    idle(5'd2);
    chk("mid_rst_count", rdata, 32'h0);

    // Random traffic against the model
    for (int k = 0; k < 1500; k++) begin
      ra = AW'($urandom_range(0, 31));
      rw = ($urandom_range(0, 2) == 0);
      rr = ($urandom_range(0, 299) == 0);
      case (ra[1:0])
        2'd0: begin
          rd = 32'($urandom_range(0, 7));
          if ($urandom_range(0, 1) == 1) rd |= 32'hABCD_0000;
        end
        2'd1: rd = {16'h0, 8'($urandom_range(0, 3)), 4'($urandom), 1'($urandom),
                    2'($urandom), 1'($urandom_range(0, 3) != 0)};
        2'd2: rd = 32'($urandom_range(0, 10));
        default: rd = $urandom;
      endcase
      cycle(rr, rw, ra, rd);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
